// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter types (FSM states, parity modes, 2-bit parity encodings).
// Build option: UART_TX_PARITY_EN adds the PARITY state to the frame FSM.
package uart_pkg;
   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   typedef enum logic [1:0] {PM_NONE, PM_EVEN, PM_ODD} par_mode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_TX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } tx_state_e;

   // 2'b11 is treated like PAR_NONE.
   function automatic par_mode_e decode_par(input logic [1:0] m);
      return m == PAR_EVEN ? PM_EVEN : m == PAR_ODD ? PM_ODD : m == PAR_NONE ? PM_NONE : PM_NONE;
   endfunction
endpackage

// File: rtl/uart_tx_gen2_if.sv
// uart_tx_gen2_if: producer-side write bus of the UART transmitter.
//   wr_en/wr_data : write request and word (master -> slave)
//   full/empty    : FIFO status (slave -> master)
interface uart_tx_gen2_if #(
   parameter int DATA_W = 8
);
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              full;
   logic              empty;

   modport master (output wr_en, wr_data, input full, empty);
   modport slave  (input wr_en, wr_data, output full, empty);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous DATA_W x FIFO_DEPTH FIFO with full/empty from pointer-plus-wrap-bit.
//   clk, rst_n            : clock, asynchronous active-low reset
//   wr_en_i, wr_data_i    : write port (ignored while full, even with a same-cycle pop)
//   rd_en_i, rd_data_o    : pop request and head word (head is valid whenever !empty_o)
//   full_o, empty_o       : occupancy flags
module uart_tx_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              full_o,
   output logic              empty_o
);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
   logic              push, pop;

   assign push      = wr_en_i & ~full_o;
   assign pop       = rd_en_i & ~empty_o;
   assign empty_o   = wptr_q == rptr_q;
   // Same slot but different lap: the writer is one full wrap ahead.
   assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign rd_data_o = mem_q[rptr_q[AW-1:0]];
   assign wptr_d    = push ? wptr_q + 1'b1 : wptr_q;
   assign rptr_d    = pop ? rptr_q + 1'b1 : rptr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
   end
endmodule

// File: rtl/uart_tx_gen2.sv
// uart_tx_gen2: buffered UART transmitter, LSB-first, programmable baud, optional parity, 1/2 stop bits.
//   clk, rst_n           : clock, asynchronous active-low reset
//   bus (slave)          : wr_en/wr_data in, full/empty out
//   baud_div             : bit period minus one, in clocks (latched per frame)
//   par_mode, two_stop   : parity (00/11 none, 01 even, 10 odd) and stop-bit count (latched per frame)
//   tx_busy, tx_done, TX : frame on line, end-of-frame pulse, registered serial line (idle high)
// Build option: define UART_TX_PARITY_EN to compile in the parity bit; otherwise par_mode is ignored.
module uart_tx_gen2
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int BAUD_W     = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   uart_tx_gen2_if.slave     bus,
   input  logic [BAUD_W-1:0] baud_div,
   input  logic [1:0]        par_mode,
   input  logic              two_stop,
   output logic              tx_busy,
   output logic              tx_done,
   output logic              TX
);
   localparam int BW = $clog2(DATA_W);

   tx_state_e         state_q, state_d;
   logic [BAUD_W-1:0] cnt_q, cnt_d, div_q, div_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d, head;
   logic              two_q, two_d;
   logic              load, pop, tick, line;
   logic              done_d, done_q, tx_q, busy_q, tx_done_q;
`ifdef UART_TX_PARITY_EN
   logic              par_en_q, par_en_d, par_bit_q, par_bit_d;
   par_mode_e         pm;
   assign pm = decode_par(par_mode);
`else
   logic              unused_par;
   assign unused_par = ^par_mode;
`endif

   uart_tx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (bus.wr_en),
      .wr_data_i (bus.wr_data),
      .rd_en_i   (pop),
      .rd_data_o (head),
      .full_o    (bus.full),
      .empty_o   (bus.empty)
   );

   assign tick    = cnt_q == div_q;
   assign pop     = load;
   assign TX      = tx_q;
   assign tx_busy = busy_q;
   assign tx_done = tx_done_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      div_d   = div_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      two_d   = two_q;
      load    = 1'b0;
      done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
`endif
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            load  = ~bus.empty;
         end
         ST_START: if (tick) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = ST_DATA;
         end
         ST_DATA: if (tick) begin
            cnt_d   = '0;
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
            if (bit_q == BW'(DATA_W - 1)) begin
               bit_d   = '0;
`ifdef UART_TX_PARITY_EN
               state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
               state_d = ST_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: if (tick) begin
            cnt_d   = '0;
            state_d = ST_STOP;
         end
`endif
         // bit_q counts stop periods; it arrives here cleared from DATA.
         ST_STOP: if (tick) begin
            cnt_d = '0;
            if (two_q && bit_q == '0) begin
               bit_d = BW'(1);
            end else begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
               load    = ~bus.empty;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Frame start: pop head and freeze this frame's configuration.
      if (load) begin
         state_d = ST_START;
         cnt_d   = '0;
         bit_d   = '0;
         shift_d = head;
         div_d   = baud_div;
         two_d   = two_stop;
`ifdef UART_TX_PARITY_EN
         par_en_d  = pm != PM_NONE;
         par_bit_d = pm == PM_EVEN ? ^head : ~^head;
`endif
      end
   end

   always_comb begin
      line = 1'b1;
      case (state_q)
         ST_START:  line = 1'b0;
         ST_DATA:   line = shift_q[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: line = par_bit_q;
`endif
         default:   line = 1'b1;
      endcase
   end

   // Line, busy and done are registered from the state one clock late, so the
   // start bit appears two clocks after a write into an idle, empty FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         div_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         two_q     <= 1'b0;
         done_q    <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         two_q     <= two_d;
         done_q    <= done_d;
         tx_q      <= line;
         busy_q    <= state_q != ST_IDLE;
         tx_done_q <= done_q;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
`endif
      end
   end
endmodule

// File: tb/tb_uart_tx_gen2.sv
// tb_uart_tx_gen2: randomized and directed bench for uart_tx_gen2 against a frame-schedule model.
module tb_uart_tx_gen2;
   localparam int DW = 8, DEPTH = 4, BW = 12;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR_ON = 1'b1;
`else
   localparam bit PAR_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [BW-1:0] baud_div = BW'(3);
   logic [1:0]    par_mode = 2'b00;
   logic          two_stop = 1'b0;
   logic          tx_busy, tx_done, TX;
   int            tests = 0, fails = 0;

   uart_tx_gen2_if #(.DATA_W(DW)) bus ();

   uart_tx_gen2 #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .BAUD_W(BW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .baud_div (baud_div),
      .par_mode (par_mode),
      .two_stop (two_stop),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done),
      .TX       (TX)
   );

   always #5 clk = ~clk;

   // Model: each frame is a scheduled window [start, stop) of bit periods.
   typedef struct {
      int          start;
      int          stop;
      int          per;
      logic [15:0] bits;
   } frame_t;

   frame_t          cur, prv;
   logic [DW-1:0]   mq[$];
   int              edge_n = 0;
   bit              was_full;
   logic            exp_tx = 1'b1, exp_busy = 1'b0, exp_done = 1'b0, exp_full = 1'b0, exp_empty = 1'b1;

   function automatic frame_t make_frame(input int start, input logic [DW-1:0] d, input int div,
                                         input logic [1:0] pm, input logic ts);
      frame_t f;
      int     n;
      logic   has_par;
      has_par = 1'b0;
`ifdef UART_TX_PARITY_EN
      has_par = pm == 2'b01 || pm == 2'b10;
`endif
      f.bits    = '1;
      f.bits[0] = 1'b0;
      for (int i = 0; i < DW; i++) f.bits[1+i] = d[i];
      n = 1 + DW;
      if (has_par) begin
         f.bits[n] = pm == 2'b01 ? ^d : ~^d;
         n++;
      end
      n += ts ? 2 : 1;
      f.start = start;
      f.per   = div + 1;
      f.stop  = start + n * f.per;
      return f;
   endfunction

   function automatic bit in_frame(input frame_t f, input int e);
      return f.per > 0 && e >= f.start && e < f.stop;
   endfunction

   always @(posedge clk) begin
      edge_n++;
      if (!rst_n) begin
         mq.delete();
         cur.per = 0; cur.start = 0; cur.stop = 0; cur.bits = '1;
         prv = cur;
      end else begin
         was_full = mq.size() == DEPTH;
         // A queued word starts the cycle after the line becomes free, or two cycles after its write.
         if (mq.size() > 0 && edge_n + 1 >= cur.stop) begin
            prv = cur;
            cur = make_frame(edge_n + 1, mq.pop_front(), int'(baud_div), par_mode, two_stop);
         end
         if (bus.wr_en && !was_full) mq.push_back(bus.wr_data);
      end
      exp_tx    = in_frame(cur, edge_n) ? cur.bits[(edge_n - cur.start) / cur.per] :
                  in_frame(prv, edge_n) ? prv.bits[(edge_n - prv.start) / prv.per] : 1'b1;
      exp_busy  = in_frame(cur, edge_n) || in_frame(prv, edge_n);
      exp_done  = (cur.per > 0 && edge_n == cur.stop) || (prv.per > 0 && edge_n == prv.stop);
      exp_empty = mq.size() == 0;
      exp_full  = mq.size() == DEPTH;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check("model_TX", TX, exp_tx);
         check("model_tx_busy", tx_busy, exp_busy);
         check("model_tx_done", tx_done, exp_done);
         check("model_full", bus.full, exp_full);
         check("model_empty", bus.empty, exp_empty);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic put(input logic [DW-1:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      tick();
      bus.wr_en   = 1'b0;
   endtask

   task automatic settle();
      int k;
      for (k = 0; k < 20000 && !(mq.size() == 0 && edge_n > cur.stop); k++) tick();
      check("idle_reached", k < 20000, 1);
   endtask

   initial begin
      int          n, dones, gaps;
      logic [9:0]  seq;
      bus.wr_en   = 1'b0;
      bus.wr_data = '0;
      repeat (2) tick();
      check("rst_TX", TX, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_done", tx_done, 0);
      check("rst_full", bus.full, 0);
      check("rst_empty", bus.empty, 1);
      rst_n = 1'b1;
      tick();

      // 0xA5, 4 clocks per bit, 8N1
      seq = 10'b1101001010;
      put(8'hA5);
      n = edge_n;
      check("a5_empty_after_write", bus.empty, 0);
      for (int k = 1; k <= 42; k++) begin
         tick();
         if (k <= 41) check("a5_tx", TX, k == 1 ? 1'b1 : seq[(k-2)/4]);
         if (k == 1) check("a5_empty_after_pop", bus.empty, 1);
         if (k >= 41) check("a5_done", tx_done, k == 42);
      end

      // parity on 0x07: even -> 1, odd -> 0 (parity period covers clocks 38..41)
      settle();
      par_mode = 2'b01;
      put(8'h07);
      n = edge_n;
      for (int k = 1; k <= 2 + (10 + PAR_ON) * 4; k++) begin
         tick();
         if (k == 38) check("even_par_bit", TX, 1);
         if (k >= 2 + (10 + PAR_ON) * 4 - 1) check("even_done", tx_done, k == 2 + (10 + PAR_ON) * 4);
      end
      settle();
      par_mode = 2'b10;
      put(8'h07);
      n = edge_n;
      for (int k = 1; k <= 2 + (10 + PAR_ON) * 4; k++) begin
         tick();
         if (k == 38) check("odd_par_bit", TX, PAR_ON ? 1'b0 : 1'b1);
         if (k >= 2 + (10 + PAR_ON) * 4 - 1) check("odd_done", tx_done, k == 2 + (10 + PAR_ON) * 4);
      end

      // two stop bits, 10 clocks per bit, 0x00: 90 low, 20 high
      settle();
      par_mode = 2'b00;
      two_stop = 1'b1;
      baud_div = BW'(9);
      put(8'h00);
      n = edge_n;
      for (int k = 1; k <= 112; k++) begin
         tick();
         if (k >= 2 && k <= 91) check("two_stop_low", TX, 0);
         if (k >= 92 && k <= 111) check("two_stop_high", TX, 1);
         if (k >= 111) check("two_stop_done", tx_done, k == 112);
      end

      // six back-to-back writes into a 4-deep FIFO
      settle();
      two_stop = 1'b0;
      baud_div = BW'(99);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         put(DW'(8'h30 + i));
         if (i == 0) n = edge_n;
         if (i == 3) check("full_after_4th", bus.full, 0);
         if (i == 4) check("full_after_5th", bus.full, 1);
      end
      dones = 0;
      gaps  = 0;
      while (edge_n < n + 5003) begin
         tick();
         dones += int'(tx_done);
         if (edge_n >= n + 2 && edge_n < n + 5002 && !tx_busy) gaps++;
      end
      check("b2b_done_count", dones, 5);
      check("b2b_busy_gaps", gaps, 0);

      // baud change mid-frame applies to the next frame only
      settle();
      baud_div = BW'(3);
      put(8'h55);
      n = edge_n;
      put(8'hFF);
      repeat (3) tick();
      baud_div = BW'(7);
      while (edge_n < n + 122) begin
         tick();
         if (edge_n == n + 42) begin
            check("chg_first_done", tx_done, 1);
            check("chg_second_start", TX, 0);
         end
         if (edge_n == n + 49) check("chg_start_8clk", TX, 0);
         if (edge_n == n + 50) check("chg_bit0", TX, 1);
         if (edge_n == n + 121) check("chg_done_early", tx_done, 0);
      end
      check("chg_second_done", tx_done, 1);

      // reset in the middle of DATA
      settle();
      baud_div = BW'(3);
      put(8'hFF);
      n = edge_n;
      put(8'h12);
      while (edge_n < n + 10) tick();
      check("pre_rst_empty", bus.empty, 0);
      check("pre_rst_busy", tx_busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_TX", TX, 1);
      check("mid_rst_busy", tx_busy, 0);
      check("mid_rst_empty", bus.empty, 1);
      check("mid_rst_done", tx_done, 0);
      tick();
      tick();
      rst_n = 1'b1;
      dones = 0;
      repeat (60) begin
         tick();
         dones += int'(tx_done);
      end
      check("post_rst_no_done", dones, 0);

      // randomized traffic with occasional configuration changes
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 199) == 0) begin
            baud_div = BW'($urandom_range(0, 4));
            par_mode = 2'($urandom_range(0, 3));
            two_stop = 1'($urandom_range(0, 1));
         end
         bus.wr_en   = $urandom_range(0, 5) == 0;
         bus.wr_data = DW'($urandom);
         tick();
      end
      bus.wr_en = 1'b0;
      settle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      fails++;
      $display("FAIL watchdog: got time limit reached, expected bench completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_tx_gen2.md
# uart_tx_gen2

Parametrised, buffered UART transmitter; next generation of the fixed 8N1 serializer. Accepts bytes from any on-chip producer into a small FIFO and serializes them LSB-first on `TX` with a runtime-programmable baud divisor, selectable parity and one or two stop bits. Sits between command/telemetry logic and the board-level serial pin; frames stream back-to-back without idle gaps while the FIFO holds data.

## Interface
- `DATA_W`, default 8, data bits per frame; legal range 5..8.
- `FIFO_DEPTH`, default 4, buffered words; power of two, ≥2.
- `BAUD_W`, default 12, width of the baud divisor.

- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `baud_div` in BAUD_W: bit period minus one, in clocks.
- `par_mode` in 2: 00/11 none, 01 even, 10 odd.
- `two_stop` in 1: 1 = two stop bits.
- `wr_en` in 1: write request.
- `wr_data` in DATA_W: word to send.
- `full` out 1: FIFO holds FIFO_DEPTH words.
- `empty` out 1: FIFO holds no words.
- `tx_busy` out 1: a frame is on the line.
- `tx_done` out 1: one-cycle pulse at frame end.
- `TX` out 1: serial line, idle high, registered.

## Operation
- Write accepted when `wr_en & !full`. Write while `full` is dropped, even if a pop occurs the same cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on `!empty`, pop head word into shift register, latch `baud_div`, `par_mode`, `two_stop`; go START. Config changes mid-frame take effect only at the next frame.
- START: TX=0 for one bit period → DATA.
- DATA: DATA_W bits LSB-first; bit counter 0..DATA_W-1 → PARITY if parity enabled, else STOP.
- PARITY: even → `^data`, odd → `~^data` → STOP.
- STOP: TX=1 for one (or two) bit periods. On completion, pulse `tx_done`; if `!empty`, pop and go directly to START (no idle cycle), else IDLE.
- Bit period = `baud_div`+1 clocks; baud counter clears on every bit boundary and frame start. `baud_div`=0 is legal (1 clock/bit).
- `tx_busy` high in START through STOP, low in IDLE.

## Timing
- Reset values: `TX`=1, `tx_busy`=0, `tx_done`=0, `empty`=1, `full`=0; FIFO pointers cleared, FSM in IDLE.
- Reset mid-frame: `TX` returns high immediately (asynchronously); queued data discarded.
- Write accepted at edge N into empty FIFO while IDLE: `empty` low after N, pop at N+1, start bit on `TX` from N+2.
- Frame length = 1 + DATA_W + parity(0/1) + stop(1/2) bit periods.
- `tx_done` high exactly one clock: the first clock after the last stop bit period (coincident with next start bit when back-to-back).
- `full`/`empty` update the clock after the causing write/pop; simultaneous write and pop with FIFO neither full nor empty leaves occupancy unchanged.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state and parity generator compiled in; `par_mode` honoured.
- Not defined: no PARITY state; `par_mode` ignored; frames are always 1 + DATA_W + stop bits.

## Structure
- Shared package `uart_pkg`: FSM state enum, parity mode enum (NONE/EVEN/ODD), `PAR_*` 2-bit encodings.
- Sub-module `uart_tx_fifo`: synchronous FIFO (DATA_W × FIFO_DEPTH) with `full`/`empty`, write/pop ports, pointer-plus-wrap-bit occupancy; reused later by the receiver.
- Top holds FSM, baud counter, bit counter, shift register, parity bit.

## Test plan
- DATA_W=8, `baud_div`=3, no parity, one stop, write 0xA5 → TX 0,1,0,1,0,0,1,0,1,1, each 4 clocks, start at N+2; `tx_done` pulse at N+42.
- Even parity, write 0x07 → parity bit 1; odd parity, write 0x07 → 0; frame 11 bit periods.
- `two_stop`=1, `baud_div`=9, write 0x00 → TX low 90 clocks, high 20 clocks, then `tx_done`.
- FIFO_DEPTH=4, `baud_div`=99, six writes on consecutive clocks → `full` after 5th accept, 6th dropped; five frames sent back-to-back, no idle between stop and start.
- Change `baud_div` 3→7 mid-frame → current frame keeps 4-clock bits, next frame uses 8.
- Assert `rst_n` low mid-DATA → TX=1, `tx_busy`=0, `empty`=1 in same cycle; no `tx_done`.
